// File: rtl/masked_xor_refresh_pipe_if.sv
// Handshake bundle for the masked XOR/refresh pipe: operand, randomness and result channels.
interface masked_xor_refresh_pipe_if #(
    parameter int unsigned NSHARES = 8,
    parameter int unsigned WIDTH   = 8
);
    localparam int unsigned SW = NSHARES * WIDTH;
    localparam int unsigned RW = (NSHARES - 1) * WIDTH;

    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] x_shares;
    logic [SW-1:0] y_shares;
    logic          rnd_valid;
    logic          rnd_ready;
    logic [RW-1:0] rnd_in;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] z_shares;

    modport master (
        output in_valid, x_shares, y_shares, rnd_valid, rnd_in, out_ready,
        input  in_ready, rnd_ready, out_valid, z_shares
    );

    modport slave (
        input  in_valid, x_shares, y_shares, rnd_valid, rnd_in, out_ready,
        output in_ready, rnd_ready, out_valid, z_shares
    );
endinterface

// File: rtl/masked_xor_refresh_pipe.sv
// Two-stage masked XOR: stage A computes share-wise x^y, stage B optionally re-randomises
// the shares with fresh masks while leaving the recombined value unchanged.
module masked_xor_refresh_pipe #(
    parameter int unsigned NSHARES = 8,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned REFRESH = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    masked_xor_refresh_pipe_if.slave bus,
    output logic [CNT_W-1:0]         op_count,
    output logic                     rnd_starve
);
    localparam int unsigned SW      = NSHARES * WIDTH;
    localparam int unsigned LAST_LO = (NSHARES - 1) * WIDTH;
    localparam logic        USE_RND = (REFRESH != 0);

    logic             a_valid_q, a_valid_d;
    logic             b_valid_q, b_valid_d;
    logic [SW-1:0]    a_data_q, a_data_d;
    logic [SW-1:0]    b_data_q, b_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             b_load;
    logic             rnd_ok;
    logic             a_move;
    logic             in_ready_c;
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] r_sum;

    // Handshake decisions; flush blocks new acceptance and mask consumption.
    always_comb begin
        b_load     = !b_valid_q || bus.out_ready;
        rnd_ok     = !USE_RND || bus.rnd_valid;
        a_move     = a_valid_q && b_load && rnd_ok && !flush;
        in_ready_c = !rst && !flush && (!a_valid_q || a_move);
        in_fire    = bus.in_valid && in_ready_c;
        out_fire   = b_valid_q && bus.out_ready;
    end

    // Share-wise XOR for stage A and mask refresh for stage B.
    always_comb begin
        a_data_d = bus.x_shares ^ bus.y_shares;
        b_data_d = a_data_q;
        r_sum    = '0;
        for (int i = 0; i < int'(NSHARES) - 1; i++) begin
            r_sum = r_sum ^ bus.rnd_in[i*WIDTH +: WIDTH];
            if (USE_RND) begin
                b_data_d[i*WIDTH +: WIDTH] = a_data_q[i*WIDTH +: WIDTH] ^ bus.rnd_in[i*WIDTH +: WIDTH];
            end
        end
        // The last share absorbs every mask so the recombined XOR is preserved.
        if (USE_RND) begin
            b_data_d[LAST_LO +: WIDTH] = a_data_q[LAST_LO +: WIDTH] ^ r_sum;
        end
    end

    // Stage occupancy and completed-operation counter next state.
    always_comb begin
        a_valid_d = a_valid_q;
        b_valid_d = b_valid_q;
        cnt_d     = cnt_q;
        if (flush) begin
            a_valid_d = 1'b0;
            b_valid_d = 1'b0;
        end else begin
            if (in_fire) begin
                a_valid_d = 1'b1;
            end else if (a_move) begin
                a_valid_d = 1'b0;
            end
            if (a_move) begin
                b_valid_d = 1'b1;
            end else if (out_fire) begin
                b_valid_d = 1'b0;
            end
        end
        if (out_fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pipeline state registers; reset drops all in-flight data at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_data_q  <= '0;
            b_data_q  <= '0;
            cnt_q     <= '0;
        end else begin
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            cnt_q     <= cnt_d;
            if (in_fire) begin
                a_data_q <= a_data_d;
            end
            if (a_move) begin
                b_data_q <= b_data_d;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.rnd_ready = USE_RND && a_move;
    assign bus.out_valid = b_valid_q;
    assign bus.z_shares  = b_data_q;
    assign op_count      = cnt_q;
    assign rnd_starve    = USE_RND && a_valid_q && b_load && !bus.rnd_valid;
endmodule

// File: tb/tb_masked_xor_refresh_pipe.sv
// Bench for masked_xor_refresh_pipe: directed vector table, random streams and a
// transaction-level scoreboard of expected result shares.
module tb_masked_xor_refresh_pipe;
    localparam int unsigned N  = 8;
    localparam int unsigned W  = 8;
    localparam int unsigned SW = N * W;
    localparam int unsigned RW = (N - 1) * W;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] op_count;
    logic [3:0]  op_count4;
    logic        rnd_starve;
    logic        rnd_starve4;

    masked_xor_refresh_pipe_if #(.NSHARES(N), .WIDTH(W)) bus ();
    masked_xor_refresh_pipe_if #(.NSHARES(N), .WIDTH(W)) bus4 ();

    masked_xor_refresh_pipe #(.NSHARES(N), .WIDTH(W), .REFRESH(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus.slave),
        .op_count(op_count), .rnd_starve(rnd_starve)
    );

    // Narrow-counter copy fed with identical stimulus.
    masked_xor_refresh_pipe #(.NSHARES(N), .WIDTH(W), .REFRESH(1), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus4.slave),
        .op_count(op_count4), .rnd_starve(rnd_starve4)
    );

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.x_shares  = bus.x_shares;
    assign bus4.y_shares  = bus.y_shares;
    assign bus4.rnd_valid = bus.rnd_valid;
    assign bus4.rnd_in    = bus.rnd_in;
    assign bus4.out_ready = bus.out_ready;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [SW-1:0] sh;
        logic [W-1:0]  rec;
    } item_t;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic [W-1:0] exp_rec;
    } vec_t;

    item_t qa[$];
    item_t qb[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] recomb(input logic [SW-1:0] s);
        logic [W-1:0] acc = '0;
        for (int i = 0; i < int'(N); i++) acc = acc ^ s[i*W +: W];
        return acc;
    endfunction

    // Random Boolean sharing of value v.
    function automatic logic [SW-1:0] split(input logic [W-1:0] v);
        logic [SW-1:0] s   = '0;
        logic [W-1:0]  acc = '0;
        for (int i = 0; i < int'(N) - 1; i++) begin
            s[i*W +: W] = W'($urandom);
            acc = acc ^ s[i*W +: W];
        end
        s[(N-1)*W +: W] = acc ^ v;
        return s;
    endfunction

    function automatic logic [RW-1:0] fill_rnd(input logic [W-1:0] b);
        logic [RW-1:0] r = '0;
        for (int i = 0; i < int'(N) - 1; i++) r[i*W +: W] = b;
        return r;
    endfunction

    function automatic logic [RW-1:0] rand_rnd();
        logic [RW-1:0] r = '0;
        for (int i = 0; i < int'(N) - 1; i++) r[i*W +: W] = W'($urandom);
        return r;
    endfunction

    // Expected refreshed shares: r_i on share i, XOR of all masks on the last share.
    function automatic logic [SW-1:0] refresh_model(input logic [SW-1:0] a, input logic [RW-1:0] r);
        logic [SW-1:0] z = a;
        logic [W-1:0]  t = '0;
        for (int i = 0; i < int'(N) - 1; i++) begin
            z[i*W +: W] = z[i*W +: W] ^ r[i*W +: W];
            t = t ^ r[i*W +: W];
        end
        z[(N-1)*W +: W] = z[(N-1)*W +: W] ^ t;
        return z;
    endfunction

    // Scoreboard update from the handshakes visible in the current cycle.
    task automatic observe();
        item_t it;
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            chk("out_valid_vs_model", 64'(bus.out_valid), 64'(qb.size() != 0));
            if (bus.out_valid && bus.out_ready) begin
                if (qb.size() == 0) begin
                    chk("unexpected_output", 64'(1), 64'(0));
                end else begin
                    it = qb.pop_front();
                    chk("z_shares", 64'(bus.z_shares), 64'(it.sh));
                    chk("z_recombined", 64'(recomb(bus.z_shares)), 64'(it.rec));
                end
            end
            if (flush) begin
                qa.delete();
                qb.delete();
            end else begin
                if (bus.rnd_valid && bus.rnd_ready) begin
                    if (qa.size() == 0) begin
                        chk("rnd_consumed_without_data", 64'(1), 64'(0));
                    end else begin
                        it = qa.pop_front();
                        it.sh = refresh_model(it.sh, bus.rnd_in);
                        qb.push_back(it);
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    it.sh  = bus.x_shares ^ bus.y_shares;
                    it.rec = recomb(bus.x_shares) ^ recomb(bus.y_shares);
                    qa.push_back(it);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic offer_random();
        bus.in_valid = 1'b1;
        bus.x_shares = split(W'($urandom));
        bus.y_shares = split(W'($urandom));
    endtask

    // Asynchronous reset check: outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_op_count", 64'(op_count), 64'(0));
        chk("rst_op_count4", 64'(op_count4), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_rnd_ready", 64'(bus.rnd_ready), 64'(0));
        chk("rst_z_shares", 64'(bus.z_shares), 64'(0));
        chk("rst_rnd_starve", 64'(rnd_starve), 64'(0));
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    endtask

    vec_t          tbl[4];
    logic [SW-1:0] xs, ys, a, zcap;
    logic [15:0]   cnt0;
    int            nxt;
    logic          acc;

    initial begin
        rst           = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.x_shares  = '0;
        bus.y_shares  = '0;
        bus.rnd_valid = 1'b0;
        bus.rnd_in    = '0;
        bus.out_ready = 1'b0;
        #1;
        do_reset();

        // Directed vectors: single operation, 2-cycle latency, explicit share values.
        tbl[0] = '{x: 8'hAA, y: 8'hF0, r: 8'h01, exp_rec: 8'h5A};
        tbl[1] = '{x: 8'h00, y: 8'h00, r: 8'hFF, exp_rec: 8'h00};
        tbl[2] = '{x: 8'hFF, y: 8'h0F, r: 8'h80, exp_rec: 8'hF0};
        tbl[3] = '{x: 8'h3C, y: 8'hC3, r: 8'h00, exp_rec: 8'hFF};
        for (int k = 0; k < 4; k++) begin
            xs = split(tbl[k].x);
            ys = split(tbl[k].y);
            bus.x_shares  = xs;
            bus.y_shares  = ys;
            bus.in_valid  = 1'b1;
            bus.rnd_in    = fill_rnd(tbl[k].r);
            bus.rnd_valid = 1'b1;
            bus.out_ready = 1'b1;
            #1;
            chk("tbl_in_ready", 64'(bus.in_ready), 64'(1));
            step();
            bus.in_valid = 1'b0;
            chk("tbl_out_valid_lat1", 64'(bus.out_valid), 64'(0));
            step();
            chk("tbl_out_valid_lat2", 64'(bus.out_valid), 64'(1));
            a = xs ^ ys;
            // Seven equal masks XOR to the mask itself, so every share sees r once.
            for (int i = 0; i < int'(N); i++) begin
                chk("tbl_share", 64'(bus.z_shares[i*W +: W]), 64'(a[i*W +: W] ^ tbl[k].r));
            end
            chk("tbl_recomb", 64'(recomb(bus.z_shares)), 64'(tbl[k].exp_rec));
            step();
        end

        // Back-to-back stream of 16 random pairs.
        do_reset();
        bus.out_ready = 1'b1;
        bus.rnd_valid = 1'b1;
        for (int k = 0; k < 18; k++) begin
            if (k < 16) offer_random();
            else bus.in_valid = 1'b0;
            bus.rnd_in = rand_rnd();
            #1;
            if (k < 16) chk("stream_in_ready", 64'(bus.in_ready), 64'(1));
            step();
            if (k >= 1 && k <= 16) chk("stream_out_valid", 64'(bus.out_valid), 64'(1));
        end
        chk("stream_op_count", 64'(op_count), 64'(16));
        chk("stream_out_idle", 64'(bus.out_valid), 64'(0));

        // Backpressure: three offered, two accepted, output held stable.
        bus.out_ready = 1'b0;
        nxt = 0;
        zcap = '0;
        for (int c = 0; c < 5; c++) begin
            if (nxt < 3 && !(bus.in_valid && c > 0 && !acc)) offer_random();
            bus.rnd_in = rand_rnd();
            #1;
            acc = bus.in_valid && bus.in_ready;
            step();
            if (acc) nxt++;
            if (c == 1) zcap = bus.z_shares;
        end
        chk("hold_accepted", 64'(nxt), 64'(2));
        chk("hold_in_ready", 64'(bus.in_ready), 64'(0));
        chk("hold_out_valid", 64'(bus.out_valid), 64'(1));
        chk("hold_z_stable", 64'(bus.z_shares), 64'(zcap));
        cnt0 = op_count;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) step();
        chk("hold_release_count", 64'(16'(op_count - cnt0)), 64'(2));
        chk("hold_release_idle", 64'(bus.out_valid), 64'(0));

        // Randomness starvation with stage A full.
        bus.rnd_valid = 1'b0;
        offer_random();
        step();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("starve_flag", 64'(rnd_starve), 64'(1));
            chk("starve_out_valid", 64'(bus.out_valid), 64'(0));
            chk("starve_rnd_ready", 64'(bus.rnd_ready), 64'(0));
            step();
        end
        bus.rnd_valid = 1'b1;
        bus.rnd_in    = rand_rnd();
        #1;
        chk("starve_rnd_ready_pulse", 64'(bus.rnd_ready), 64'(1));
        chk("starve_flag_clear", 64'(rnd_starve), 64'(0));
        step();
        chk("starve_out_valid_after", 64'(bus.out_valid), 64'(1));
        chk("starve_rnd_ready_once", 64'(bus.rnd_ready), 64'(0));
        step();

        // Counter wrap: 17 results on the 4-bit copy.
        do_reset();
        bus.out_ready = 1'b1;
        bus.rnd_valid = 1'b1;
        for (int k = 0; k < 19; k++) begin
            if (k < 17) offer_random();
            else bus.in_valid = 1'b0;
            bus.rnd_in = rand_rnd();
            step();
        end
        chk("wrap_op_count16", 64'(op_count), 64'(17));
        chk("wrap_op_count4", 64'(op_count4), 64'(1));

        // Flush with both stages full; output handshake in the flush cycle still counts.
        bus.out_ready = 1'b0;
        offer_random();
        step();
        offer_random();
        step();
        bus.in_valid = 1'b0;
        chk("flush_pre_out_valid", 64'(bus.out_valid), 64'(1));
        bus.out_ready = 1'b1;
        flush = 1'b1;
        cnt0  = op_count;
        #1;
        chk("flush_in_ready", 64'(bus.in_ready), 64'(0));
        chk("flush_rnd_ready", 64'(bus.rnd_ready), 64'(0));
        step();
        flush = 1'b0;
        #1;
        chk("flush_out_valid", 64'(bus.out_valid), 64'(0));
        chk("flush_count", 64'(16'(op_count - cnt0)), 64'(1));
        chk("flush_in_ready_after", 64'(bus.in_ready), 64'(1));
        step();
        chk("flush_stays_empty", 64'(bus.out_valid), 64'(0));

        // Asynchronous reset in the middle of a stream.
        for (int k = 0; k < 3; k++) begin
            offer_random();
            bus.rnd_in = rand_rnd();
            step();
        end
        chk("midrst_busy", 64'(bus.out_valid), 64'(1));
        do_reset();
        bus.in_valid = 1'b0;
        step();
        chk("midrst_no_output", 64'(bus.out_valid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
